// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result stage:
//   - opcode encodings of the upstream 32-bit combinational ALU
//   - bit positions inside the 4-bit V/Z/N/C status word
//   - 4-bit branch condition codes and their evaluation against NZCV flags
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 32;

    // Opcode that produced a result; only OP_ADD carries meaningful V and C.
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_XOR  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_NOR  = 3'd4,
        OP_SRL  = 3'd5,
        OP_SLL  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    // Bit positions in both the ALU stat word and the committed flag register.
    localparam int STAT_V = 3;
    localparam int STAT_Z = 2;
    localparam int STAT_N = 1;
    localparam int STAT_C = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    // Evaluate a condition code against a flag word laid out as {V,Z,N,C}.
    function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
        logic v, z, n, c;
        logic res;
        v   = f[STAT_V];
        z   = f[STAT_Z];
        n   = f[STAT_N];
        c   = f[STAT_C];
        res = 1'b0;
        case (cond_e'(code))
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;  // COND_NV
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// -----------------------------------------------------------------------------
// alu_skid_buf
// Two-entry FIFO holding {result, dest} between the ALU and its consumer.
// in_ready comes from registered occupancy only, so upstream never sees a
// combinational path from out_ready.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (push = in_valid & in_ready)
//   in_result, in_dest  payload written on push
//   out_valid/out_ready downstream handshake (pop = out_valid & out_ready)
//   out_result,out_dest head entry; last popped entry while empty
// -----------------------------------------------------------------------------
module alu_skid_buf
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,   // only 2 is supported: pointers are 1 bit
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [TAG_W-1:0]  in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_dest
);

    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] result_q [DEPTH];
    logic [TAG_W-1:0]  dest_q   [DEPTH];

    logic push;
    logic pop;
    logic head_idx;

    assign in_ready  = ~rst & (count_q != 2'(DEPTH));
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // When empty, the slot behind rd_ptr is the entry popped last, so pointing
    // there keeps out_result/out_dest holding their last values for free.
    assign head_idx   = out_valid ? rd_ptr_q : ~rd_ptr_q;
    assign out_result = result_q[head_idx];
    assign out_dest   = dest_q[head_idx];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;   // idle, or push+pop at count 1
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            // NOTE: the storage is reset too: it is only two entries, and the
            // empty-buffer output reads it directly, so it must show zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                result_q[i] <= '0;
                dest_q[i]   <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                result_q[wr_ptr_q] <= in_result;
                dest_q[wr_ptr_q]   <= in_dest;
            end
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
// Registered result stage behind the 32-bit ALU: buffers results in a 2-entry
// skid buffer and commits the architectural NZCV flags at push time.
//
// Optional feature (macro ALU_RESULT_STAGE_COND_EN): adds cond_code/cond_true,
// a combinational branch-condition evaluation on the committed flags.
//
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      upstream handshake
//   in_result, in_stat     ALU result and {V,Z,N,C} status
//   in_sel, in_flag_we     producing opcode, flag-update enable
//   in_dest                destination tag
//   out_valid/out_ready    downstream handshake
//   out_result, out_dest   head result and tag
//   flags                  committed {V,Z,N,C}
//   cond_code, cond_true   condition select/result (macro only)
// -----------------------------------------------------------------------------
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_stat,
    input  logic [2:0]        in_sel,
    input  logic              in_flag_we,
    input  logic [TAG_W-1:0]  in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_dest,
    output logic [3:0]        flags
`ifdef ALU_RESULT_STAGE_COND_EN
    ,
    input  logic [3:0]        cond_code,
    output logic              cond_true
`endif
);

    logic [3:0] flags_q, flags_d;
    logic       push;

    alu_skid_buf #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_dest    (in_dest),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dest   (out_dest)
    );

    assign push = in_valid & in_ready;

    // Flags commit at the push edge. Only ADD produces meaningful V/C, so the
    // logical/shift ops update N and Z and leave V and C untouched.
    always_comb begin
        flags_d = flags_q;
        if (push && in_flag_we) begin
            flags_d[STAT_N] = in_stat[STAT_N];
            flags_d[STAT_Z] = in_stat[STAT_Z];
            if (in_sel == OP_ADD) begin
                flags_d[STAT_V] = in_stat[STAT_V];
                flags_d[STAT_C] = in_stat[STAT_C];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

`ifdef ALU_RESULT_STAGE_COND_EN
    // Gated by rst so codes such as AL/NE do not read 1 during reset.
    assign cond_true = ~rst & eval_cond(cond_code, flags_q);
`endif

endmodule
